// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution pipeline: opcodes, widths and
// the pipeline-stage record carried between S1 and S2.
package branch_pkg;

  localparam int BR_XLEN = 32;
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] BR_BEQ    = 3'd0;
  localparam logic [OP_W-1:0] BR_BNE    = 3'd1;
  localparam logic [OP_W-1:0] BR_BLEZ   = 3'd2;
  localparam logic [OP_W-1:0] BR_BGTZ   = 3'd3;
  localparam logic [OP_W-1:0] BR_BLTZ   = 3'd4;
  localparam logic [OP_W-1:0] BR_BGEZ   = 3'd5;
  localparam logic [OP_W-1:0] BR_BLTZAL = 3'd6;
  localparam logic [OP_W-1:0] BR_BGEZAL = 3'd7;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [BR_XLEN-1:0] rs;
    logic [BR_XLEN-1:0] rt;
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] target;
    logic               valid;
  } stage_t;

  // Only the two-register compares look at rt; everything else compares rs to zero.
  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/signed_compare_32bit.sv
// Shared 32-bit signed magnitude comparator. Outputs are all low when disabled.
module signed_compare_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_en,
  output logic        o_bigger,
  output logic        o_equal,
  output logic        o_less
);

  // Signed compare of a against b, gated by the enable.
  always_comb begin
    o_bigger = 1'b0;
    o_equal  = 1'b0;
    o_less   = 1'b0;
    if (i_en) begin
      o_bigger = $signed(i_a) >  $signed(i_b);
      o_equal  = i_a == i_b;
      o_less   = $signed(i_a) <  $signed(i_b);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution unit: S1 captures the decoded branch, the shared
// comparator and target adder work on S1, S2 holds the registered result.
// Optional feature: define BRANCH_LINK_EN to add link-register writeback
// outputs for BLTZAL/BGEZAL.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [XLEN-1:0] in_pc,
  input  logic [15:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target
`ifdef BRANCH_LINK_EN
  ,
  output logic            out_link_we,
  output logic [XLEN-1:0] out_link_data
`endif
);

  stage_t          r_s1;
  stage_t          r_s2;
  logic [15:0]     r_s1_imm;
  logic            r_s2_taken;

  logic            w_kill;
  logic            w_drain;
  logic            w_s1_move;
  logic            w_accept;
  logic [XLEN-1:0] w_rt_eff;
  logic [XLEN-1:0] w_target;
  logic            w_cmp_gt;
  logic            w_cmp_eq;
  logic            w_cmp_lt;
  logic            w_taken;
  logic            w_unused;

  // Handshake: S2 drains on consumer take, S1 advances into an empty or draining S2.
  assign w_kill    = rst | flush;
  assign w_drain   = r_s2.valid & out_ready;
  assign w_s1_move = r_s1.valid & (~r_s2.valid | w_drain);
  assign in_ready  = ~w_kill & (~r_s1.valid | w_s1_move);
  assign w_accept  = in_valid & in_ready;

  assign w_rt_eff  = uses_rt(in_op) ? in_rt : '0;

  // Target arithmetic wraps modulo 2^XLEN by construction.
  assign w_target  = r_s1.pc + XLEN'(4) + {{(XLEN-18){r_s1_imm[15]}}, r_s1_imm, 2'b00};

  signed_compare_32bit u_cmp (
    .i_a      (r_s1.rs),
    .i_b      (r_s1.rt),
    .i_en     (1'b1),
    .o_bigger (w_cmp_gt),
    .o_equal  (w_cmp_eq),
    .o_less   (w_cmp_lt)
  );

  // Decode comparator flags into the branch condition for the S1 op.
  always_comb begin
    w_taken = 1'b0;
    case (r_s1.op)
      BR_BEQ:               w_taken = w_cmp_eq;
      BR_BNE:               w_taken = ~w_cmp_eq;
      BR_BLEZ:              w_taken = w_cmp_lt | w_cmp_eq;
      BR_BGTZ:              w_taken = w_cmp_gt;
      BR_BLTZ, BR_BLTZAL:   w_taken = w_cmp_lt;
      BR_BGEZ, BR_BGEZAL:   w_taken = w_cmp_gt | w_cmp_eq;
      default:              w_taken = 1'b0;
    endcase
  end

  // S1 register: capture accepted ops, empty when the op moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s1_imm <= '0;
    end else if (flush) begin
      r_s1.valid <= 1'b0;
    end else if (w_accept) begin
      r_s1.op    <= in_op;
      r_s1.rs    <= in_rs;
      r_s1.rt    <= w_rt_eff;
      r_s1.pc    <= in_pc;
      r_s1.valid <= 1'b1;
      r_s1_imm   <= in_imm;
    end else if (w_s1_move) begin
      r_s1.valid <= 1'b0;
    end
  end

  // S2 register: result holds while stalled, loads only when S1 advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2       <= '0;
      r_s2_taken <= 1'b0;
    end else if (flush) begin
      r_s2.valid <= 1'b0;
    end else if (w_s1_move) begin
      r_s2.op     <= r_s1.op;
      r_s2.pc     <= r_s1.pc;
      r_s2.target <= w_target;
      r_s2.valid  <= 1'b1;
      r_s2_taken  <= w_taken;
    end else if (w_drain) begin
      r_s2.valid <= 1'b0;
    end
  end

  assign out_valid  = r_s2.valid;
  assign out_taken  = r_s2_taken;
  assign out_target = r_s2.target;

`ifdef BRANCH_LINK_EN
  logic            r_s2_link_we;
  logic [XLEN-1:0] r_s2_link_data;

  // Link data is registered alongside S2 so it reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_link_we   <= 1'b0;
      r_s2_link_data <= '0;
    end else if (!flush && w_s1_move) begin
      r_s2_link_we   <= (r_s1.op == BR_BLTZAL) || (r_s1.op == BR_BGEZAL);
      r_s2_link_data <= r_s1.pc + XLEN'(8);
    end
  end

  assign out_link_we   = r_s2.valid & r_s2_link_we;
  assign out_link_data = r_s2_link_data;
`endif

  // Stage-record fields that this datapath never reads back.
  assign w_unused = ^{r_s1.target, r_s2.rs, r_s2.rt, r_s2.pc, r_s2.op};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (build with or without BRANCH_LINK_EN).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [31:0] in_pc = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_link_we;
  logic [31:0] out_link_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dut_acc = 0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        lwe;
    logic [31:0] ldata;
    int          age;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_target (out_target)
`ifdef BRANCH_LINK_EN
    ,
    .out_link_we   (out_link_we),
    .out_link_data (out_link_data)
`endif
  );

`ifndef BRANCH_LINK_EN
  assign out_link_we   = 1'b0;
  assign out_link_data = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the branch rules.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] rs, rt, pc,
                                 input logic [15:0] imm);
    exp_t e;
    int   srs;
    srs = $signed(rs);
    case (op)
      3'd0:       e.taken = (rs == rt);
      3'd1:       e.taken = (rs != rt);
      3'd2:       e.taken = (srs <= 0);
      3'd3:       e.taken = (srs > 0);
      3'd4, 3'd6: e.taken = (srs < 0);
      default:    e.taken = (srs >= 0);
    endcase
    e.target = pc + 32'd4 + ({{16{imm[15]}}, imm} * 32'd4);
`ifdef BRANCH_LINK_EN
    e.lwe    = (op >= 3'd6);
`else
    e.lwe    = 1'b0;
`endif
    e.ldata  = pc + 32'd8;
    e.age    = 1;
    return e;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] rs, rt, pc,
                      input logic [15:0] imm, input logic ordy, input logic fl);
    logic exp_ir, exp_ov;
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_pc = pc; in_imm = imm;
    out_ready = ordy; flush = fl;
    #1;
    exp_ir = !fl && ((q.size() < 2) || ordy);
    exp_ov = (q.size() > 0) && (q[0].age >= 2);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_taken", 32'(out_taken), 32'(q[0].taken));
      chk("out_target", out_target, q[0].target);
`ifdef BRANCH_LINK_EN
      chk("out_link_we", 32'(out_link_we), 32'(q[0].lwe));
      if (q[0].lwe) chk("out_link_data", out_link_data, q[0].ldata);
`endif
    end
    if (v && in_ready) n_dut_acc++;
    if (fl) begin
      q.delete();
    end else begin
      if (exp_ov && ordy) begin
        $display("xfer: taken=%0d target=%08h link_we=%0d", out_taken, out_target, out_link_we);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (v && exp_ir) q.push_back(model(op, rs, rt, pc, imm));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 16'd0, ordy, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_taken", 32'(out_taken), 32'd0);
    chk("rst_out_target", out_target, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BRANCH_LINK_EN
    chk("rst_link_we", 32'(out_link_we), 32'd0);
    chk("rst_link_data", out_link_data, 32'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rs, rt;
    @(negedge clk);
    do_reset(3);

    // BEQ: result visible two cycles after the accepting cycle.
    step(1'b1, 3'd0, 32'h80000000, 32'h80000000, 32'h00400000, 16'h0004, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0);
    #1;
    chk("beq_valid", 32'(out_valid), 32'd1);
    chk("beq_taken", 32'(out_taken), 32'd1);
    chk("beq_target", out_target, 32'h00400014);
    @(negedge clk);
    q.delete();
    idle(1'b1, 2);

    // Compare-against-zero boundaries, back to back.
    step(1'b1, 3'd3, 32'hFFFFFFFF, 32'h5, 32'h100, 16'h0010, 1'b1, 1'b0);
    step(1'b1, 3'd2, 32'h00000000, 32'h7, 32'h200, 16'hFFF0, 1'b1, 1'b0);
    step(1'b1, 3'd5, 32'h7FFFFFFF, 32'h0, 32'h300, 16'h8000, 1'b1, 1'b0);
    step(1'b1, 3'd1, 32'h12345678, 32'h12345678, 32'h400, 16'h7FFF, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Target wraparound.
    step(1'b1, 3'd0, 32'd1, 32'd1, 32'hFFFFFFF8, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 3'd0, 32'd1, 32'd1, 32'hFFFFFFFC, 16'h0000, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Backpressure: only two ops fit while the consumer stalls.
    n_dut_acc = 0;
    step(1'b1, 3'd4, 32'hFFFFFFF0, 32'd0, 32'h1000, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 3'd5, 32'hFFFFFFF0, 32'd0, 32'h2000, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd9, 32'd9, 32'h3000, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd9, 32'd9, 32'h3000, 16'h0003, 1'b0, 1'b0);
    chk("stall_accepts", 32'(n_dut_acc), 32'd2);
    step(1'b1, 3'd0, 32'd9, 32'd9, 32'h3000, 16'h0003, 1'b1, 1'b0);
    idle(1'b1, 4);

    // Flush with two ops in flight and a third offered.
    step(1'b1, 3'd0, 32'd1, 32'd1, 32'h5000, 16'h0004, 1'b0, 1'b0);
    step(1'b1, 3'd1, 32'd1, 32'd2, 32'h6000, 16'h0004, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd3, 32'd3, 32'h7000, 16'h0004, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    idle(1'b1, 4);

    // Link op.
    step(1'b1, 3'd6, 32'd1, 32'd0, 32'h00001000, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0);
    #1;
    chk("bltzal_taken", 32'(out_taken), 32'd0);
`ifdef BRANCH_LINK_EN
    chk("bltzal_link_we", 32'(out_link_we), 32'd1);
    chk("bltzal_link_data", out_link_data, 32'h00001008);
`endif
    @(negedge clk);
    q.delete();
    idle(1'b1, 2);

    // Randomised traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rs = $urandom();
      rt = $urandom();
      case ($urandom_range(0, 5))
        0: rs = 32'd0;
        1: rt = rs;
        2: rs = 32'hFFFFFFFF;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rs, rt, $urandom(),
           16'($urandom()), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end
    idle(1'b1, 4);

    // Reset with a stalled taken branch inside zeroes everything.
    step(1'b1, 3'd0, 32'd5, 32'd5, 32'h0ABC0000, 16'h0100, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'd5, 32'd0, 32'h0DEF0000, 16'h0200, 1'b0, 1'b0);
    idle(1'b0, 1);
    do_reset(2);
    idle(1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
